// File: rtl/quad_step_decoder.sv
// quad_step_decoder: front end for a small up/down counter.
// It takes a mechanical quadrature encoder (A/B) and a preset button. The
// three asynchronous inputs are synchronised and glitch-filtered. Gray-code
// transitions become one-cycle step pulses with a direction. A button press
// becomes a one-cycle active-low load strobe carrying the preset value.
//
// Output strobe semantics: there is no back-pressure. count_enb and ld_cnt
// (active low) are single-cycle strobes that the downstream counter must act
// on in the cycle they are asserted. updn_cnt is meaningful while count_enb=1
// and holds its last value otherwise. data_in is meaningful while ld_cnt=0
// and holds its last value otherwise.
module quad_step_decoder #(
  parameter int FILT_LEN = 4,
  parameter int DATA_W   = 3
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              enc_a,
  input  logic              enc_b,
  input  logic              ld_req_,
  input  logic [DATA_W-1:0] ld_val,
  input  logic              err_clr,
  output logic              count_enb,
  output logic              updn_cnt,
  output logic              ld_cnt,
  output logic [DATA_W-1:0] data_in,
  output logic              err
);

  // Channel index: 0 = A, 1 = B, 2 = load button (active low, idles high).
  localparam int NCH = 3;
  localparam logic [NCH-1:0] CH_RST    = 3'b100;
  localparam logic [3:0]     FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic [4:0]     START_END = 5'(FILT_LEN + 2);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync_1;
  logic [NCH-1:0] sync_2;
  logic [NCH-1:0] filt;
  logic [3:0]     filt_cnt [NCH];
  logic [4:0]     start_cnt;
  logic           startup;
  logic [1:0]     cur_ab;
  logic [1:0]     prev_ab;
  logic           prev_ld;
  logic           step_up;
  logic           step_dn;
  logic           step_bad;
  logic           ld_fall;

  assign raw    = {ld_req_, enc_b, enc_a};
  assign cur_ab = {filt[0], filt[1]};

  // Two-flop synchroniser for every asynchronous input.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      sync_1 <= CH_RST;
      sync_2 <= CH_RST;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Startup window: counts FILT_LEN+2 cycles after reset release, then stops.
  // It is long enough for the synchroniser and the tracking filter to
  // settle, and for the previous-state registers to load real levels.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      start_cnt <= '0;
    end else if (startup) begin
      start_cnt <= start_cnt + 5'd1;
    end
  end

  assign startup = (start_cnt != START_END);

  // Glitch filter. A channel must disagree with its filtered value for
  // FILT_LEN consecutive cycles before the change is accepted. While the
  // startup window is open, the filtered value tracks the synchronised value.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      filt <= CH_RST;
      for (int i = 0; i < NCH; i++) begin
        filt_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (startup) begin
          filt[i]     <= sync_2[i];
          filt_cnt[i] <= '0;
        end else if (sync_2[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_LAST) begin
          filt[i]     <= sync_2[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Previous filtered levels. These load every cycle, including during
  // startup, so nothing is detected when the window closes.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prev_ab <= 2'b00;
      prev_ld <= 1'b1;
    end else begin
      prev_ab <= cur_ab;
      prev_ld <= filt[2];
    end
  end

  // x4 Gray decoder: classify the {prev,cur} pair.
  // Up sequence:   00->01->11->10->00
  // Down sequence: the reverse
  // Two-bit jumps are illegal.
  always_comb begin
    step_up  = 1'b0;
    step_dn  = 1'b0;
    step_bad = 1'b0;
    case ({prev_ab, cur_ab})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up  = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn  = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
      default: ;
    endcase
    if (startup) begin
      step_up  = 1'b0;
      step_dn  = 1'b0;
      step_bad = 1'b0;
    end
  end

  // Load request: a falling edge of the filtered button outside startup.
  // A held button or its release produces nothing further.
  assign ld_fall = !startup && prev_ld && !filt[2];

  // Step pulse and direction. The direction holds between pulses.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_enb <= 1'b0;
      updn_cnt  <= 1'b1;
    end else begin
      count_enb <= step_up | step_dn;
      if (step_up) begin
        updn_cnt <= 1'b1;
      end else if (step_dn) begin
        updn_cnt <= 1'b0;
      end
    end
  end

  // Sticky error flag. A new illegal transition wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err <= 1'b0;
    end else if (step_bad) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Load strobe, with the preset captured on the same edge. The load is not
  // arbitrated against a step; the counter downstream gives load priority.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ld_cnt  <= 1'b1;
      data_in <= '0;
    end else begin
      ld_cnt <= !ld_fall;
      if (ld_fall) begin
        data_in <= ld_val;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with FILT_LEN=4 and DATA_W=3.
// Inputs change on the falling clock edge and outputs are sampled on the
// falling edge. "Edge k" is the k-th rising edge after an input change.
module tb_quad_step_decoder;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_;
  logic       enc_a;
  logic       enc_b;
  logic       ld_req_;
  logic [2:0] ld_val;
  logic       err_clr;
  logic       count_enb;
  logic       updn_cnt;
  logic       ld_cnt;
  logic [2:0] data_in;
  logic       err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quad_step_decoder #(.FILT_LEN(4), .DATA_W(3)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .ld_req_   (ld_req_),
    .ld_val    (ld_val),
    .err_clr   (err_clr),
    .count_enb (count_enb),
    .updn_cnt  (updn_cnt),
    .ld_cnt    (ld_cnt),
    .data_in   (data_in),
    .err       (err)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];   // expected direction of each step, in order
  int n_checks   = 0;
  int n_errors   = 0;
  int steps      = 0;
  int spurious   = 0;
  int ld_strobes = 0;
  int both_cnt   = 0;
  int base_steps;
  int base_ld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: on each falling edge, counts strobes and checks the direction of
  // every step against the expected queue.
  initial begin
    logic [0:0] exp_dir;
    forever begin
      @(negedge clk);
      if (count_enb === 1'b1) begin
        steps++;
        if (exp_q.size() > 0) begin
          exp_dir = exp_q.pop_front();
          check("step_dir", {31'd0, updn_cnt}, {31'd0, exp_dir});
        end else begin
          spurious++;
        end
      end
      if (ld_cnt === 1'b0) ld_strobes++;
      if (count_enb === 1'b1 && ld_cnt === 1'b0) both_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enc_move(input logic a, input logic b, input logic dir);
    exp_q.push_back(dir);
    enc_a = a;
    enc_b = b;
    cycles(20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count_enb"}, {31'd0, count_enb}, 32'd0);
    check({tag, "_updn_cnt"},  {31'd0, updn_cnt},  32'd1);
    check({tag, "_ld_cnt"},    {31'd0, ld_cnt},    32'd1);
    check({tag, "_data_in"},   {29'd0, data_in},   32'd0);
    check({tag, "_err"},       {31'd0, err},       32'd0);
  endtask

  // Watchdog: stops the run if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ = 1'b0; enc_a = 1'b1; enc_b = 1'b1; ld_req_ = 1'b1;
    ld_val = 3'b000; err_clr = 1'b0;
    cycles(3);
    check_reset_outputs("rst");

    // Release with A=B=1 held: the startup window hides the level change.
    rst_ = 1'b1;
    cycles(100);
    check("startup_steps", steps, 0);
    check("startup_err", {31'd0, err}, 32'd0);
    check("startup_prev", {30'd0, dut.prev_ab}, 32'd3);

    // Walk 11 -> 10 -> 00 (two up steps) to reach the cycle start.
    enc_move(1'b1, 1'b0, 1'b1);
    enc_move(1'b0, 1'b0, 1'b1);
    check("walk_steps", steps, 2);

    // Full up cycle. The first step also checks latency and pulse width.
    base_steps = steps;
    exp_q.push_back(1'b1);
    enc_b = 1'b1;                          // 00 -> 01
    cycles(6);
    check("lat_edge6", {31'd0, count_enb}, 32'd0);
    cycles(1);
    check("lat_edge7", {31'd0, count_enb}, 32'd1);
    cycles(1);
    check("pulse_width", {31'd0, count_enb}, 32'd0);
    cycles(12);
    enc_move(1'b1, 1'b1, 1'b1);            // 01 -> 11
    enc_move(1'b1, 1'b0, 1'b1);            // 11 -> 10
    enc_move(1'b0, 1'b0, 1'b1);            // 10 -> 00
    check("up_steps", steps - base_steps, 4);
    check("up_dir_hold", {31'd0, updn_cnt}, 32'd1);

    // Full down cycle.
    base_steps = steps;
    enc_move(1'b1, 1'b0, 1'b0);            // 00 -> 10
    enc_move(1'b1, 1'b1, 1'b0);            // 10 -> 11
    enc_move(1'b0, 1'b1, 1'b0);            // 11 -> 01
    enc_move(1'b0, 1'b0, 1'b0);            // 01 -> 00
    check("dn_steps", steps - base_steps, 4);
    check("dn_dir_hold", {31'd0, updn_cnt}, 32'd0);

    // A 3-cycle glitch on A is shorter than the filter and gives no step.
    base_steps = steps;
    enc_a = 1'b1;
    cycles(3);
    enc_a = 1'b0;
    cycles(20);
    check("glitch_steps", steps - base_steps, 0);

    // Illegal 00 -> 11: no step, sticky err, cleared by err_clr.
    base_steps = steps;
    enc_a = 1'b1; enc_b = 1'b1;
    cycles(20);
    check("illegal_steps", steps - base_steps, 0);
    check("illegal_err", {31'd0, err}, 32'd1);
    cycles(20);
    check("err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);

    // 11 -> 01 (down), then illegal 01 -> 10 with err_clr on the same edge.
    enc_move(1'b0, 1'b1, 1'b0);
    enc_a = 1'b1; enc_b = 1'b0;
    cycles(6);
    check("err_before_set", {31'd0, err}, 32'd0);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("err_set_wins", {31'd0, err}, 32'd1);
    cycles(13);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("err_cleared2", {31'd0, err}, 32'd0);

    // Button held low for 50 cycles: exactly one strobe, preset captured.
    base_ld = ld_strobes;
    ld_val = 3'b101;
    ld_req_ = 1'b0;
    cycles(6);
    check("ld_edge6", {31'd0, ld_cnt}, 32'd1);
    cycles(1);
    check("ld_edge7", {31'd0, ld_cnt}, 32'd0);
    check("ld_data", {29'd0, data_in}, 32'd5);
    cycles(43);
    ld_req_ = 1'b1;
    cycles(20);
    check("ld_strobes", ld_strobes - base_ld, 1);
    check("ld_data_hold", {29'd0, data_in}, 32'd5);

    // A 2-cycle bounce gives no strobe and leaves data_in unchanged.
    base_ld = ld_strobes;
    ld_val = 3'b010;
    ld_req_ = 1'b0;
    cycles(2);
    ld_req_ = 1'b1;
    cycles(20);
    check("bounce_strobes", ld_strobes - base_ld, 0);
    check("bounce_data", {29'd0, data_in}, 32'd5);

    // Load and up step (10 -> 00) land on the same cycle.
    ld_val = 3'b011;
    exp_q.push_back(1'b1);
    enc_a = 1'b0;
    ld_req_ = 1'b0;
    cycles(7);
    check("align_step", {31'd0, count_enb}, 32'd1);
    check("align_load", {31'd0, ld_cnt}, 32'd0);
    cycles(20);
    ld_req_ = 1'b1;
    cycles(20);
    check("align_both", both_cnt, 1);
    check("align_data", {29'd0, data_in}, 32'd3);

    // Reset asserted while a step pulse is high (00 -> 01).
    exp_q.push_back(1'b1);
    enc_b = 1'b1;
    cycles(7);
    check("pre_rst_pulse", {31'd0, count_enb}, 32'd1);
    #2 rst_ = 1'b0;
    #1 check_reset_outputs("async_rst");
    cycles(3);
    rst_ = 1'b1;
    base_steps = steps;
    cycles(40);
    check("post_rst_steps", steps - base_steps, 0);
    check_reset_outputs("post_rst");

    // Totals: 2 walk + 4 up + 4 down + 1 down + 1 aligned + 1 pre-reset.
    check("total_steps", steps, 13);
    check("spurious_steps", spurious, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
